// File: rtl/test_sequencer.sv
// Serial test-channel sequencer: launches non-skipped channels one at a time,
// waits for done/pass or a timeout, and accumulates pass/fail/timeout results.

module test_sequencer_lane #(
  parameter int IDX_W = 1,
  parameter int LANE  = 0
) (
  input  logic             skip_in,
  input  logic             skip_lat,
  input  logic [IDX_W-1:0] idx,
  output logic             first_ok,
  output logic             next_ok
);
  assign first_ok = ~skip_in;
  assign next_ok  = ~skip_lat & (IDX_W'(LANE) > idx);
endmodule

module test_sequencer #(
  parameter int NUM_TESTS = 8,
  parameter int TIMEOUT   = 1000,
  parameter int TIMER_W   = 16,
  parameter int CNT_W     = $clog2(NUM_TESTS + 1),
  parameter int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] skip_mask,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic [NUM_TESTS-1:0] test_start,
  output logic [IDX_W-1:0]     current_test,
  output logic                 busy,
  output logic                 all_done,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [TIMER_W-1:0]   timer;
  logic [NUM_TESTS-1:0] skip_q;
  logic [NUM_TESTS-1:0] first_ok, next_ok;
  logic                 first_any, next_any;
  logic [IDX_W-1:0]     first_idx, next_idx;

  for (genvar g = 0; g < NUM_TESTS; g++) begin : g_lane
    test_sequencer_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .skip_in  (skip_mask[g]),
      .skip_lat (skip_q[g]),
      .idx      (idx),
      .first_ok (first_ok[g]),
      .next_ok  (next_ok[g])
    );
  end

  // Descending scan so the lowest eligible channel is the one that sticks.
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    next_any  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (first_ok[i]) begin
        first_any = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (next_ok[i]) begin
        next_any = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  // Launch pulse decodes from registered state, so reset kills it instantly.
  always_comb begin
    test_start = '0;
    if (state == LAUNCH) test_start[idx] = 1'b1;
  end

  assign busy         = (state == LAUNCH) || (state == WAIT);
  assign all_done     = (state == DONE);
  assign current_test = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      skip_q       <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      fail_mask    <= '0;
      timeout_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_count   <= '0;
            fail_count   <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            skip_q       <= skip_mask;
            timer        <= '0;
            if (first_any) begin
              idx   <= first_idx;
              state <= LAUNCH;
            end else begin
              state <= DONE;
            end
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (test_done[idx] || timer == TIMER_W'(TIMEOUT - 1)) begin
            if (test_done[idx] && test_pass[idx]) begin
              pass_count <= pass_count + CNT_W'(1);
            end else begin
              fail_count     <= fail_count + CNT_W'(1);
              fail_mask[idx] <= 1'b1;
              if (!test_done[idx]) timeout_mask[idx] <= 1'b1;
            end
            if (next_any) begin
              idx   <= next_idx;
              state <= LAUNCH;
            end else begin
              state <= DONE;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized bench for test_sequencer: a per-run schedule model predicts launch
// cycles, busy/all_done windows and final counters/masks.

module tb_test_sequencer;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] skip_mask = '0;
  logic [N-1:0] test_done = '0;
  logic [N-1:0] test_pass = '0;
  logic [N-1:0] test_start;
  logic [1:0]   current_test;
  logic         busy, all_done;
  logic [2:0]   pass_count, fail_count;
  logic [N-1:0] fail_mask, timeout_mask;

  int checks = 0;
  int errors = 0;
  int lat[N];          // WAIT cycle on which done rises; 0 = never answers
  logic [N-1:0] pas;

  always #5 clk = ~clk;

  test_sequencer #(.NUM_TESTS(N), .TIMEOUT(TO), .TIMER_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .skip_mask    (skip_mask),
    .test_done    (test_done),
    .test_pass    (test_pass),
    .test_start   (test_start),
    .current_test (current_test),
    .busy         (busy),
    .all_done     (all_done),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .fail_mask    (fail_mask),
    .timeout_mask (timeout_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_seq(input logic [N-1:0] skip, input bit noise);
    int launch[N];
    int dur[N];
    int t, np, nf, last, end_cyc, cur;
    logic [N-1:0] fm, tm, ets;
    t = 1; np = 0; nf = 0; fm = '0; tm = '0; last = -1;
    for (int i = 0; i < N; i++) begin
      launch[i] = -100;
      dur[i] = (lat[i] == 0) ? TO : lat[i];
      if (!skip[i]) begin
        launch[i] = t;
        t += 1 + dur[i];
        last = i;
        if (lat[i] != 0 && pas[i]) np++;
        else begin
          nf++;
          fm[i] = 1'b1;
          if (lat[i] == 0) tm[i] = 1'b1;
        end
      end
    end
    end_cyc = t;

    @(negedge clk);
    start = 1'b1; skip_mask = skip; test_done = '0;
    for (int cyc = 1; cyc <= end_cyc + 1; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      test_done = '0;
      test_pass = N'($urandom);
      if (noise) skip_mask = N'($urandom);
      ets = '0; cur = -1;
      for (int i = 0; i < N; i++) begin
        if (launch[i] == cyc) ets[i] = 1'b1;
        if (!skip[i] && cyc >= launch[i] && cyc <= launch[i] + dur[i]) cur = i;
      end
      check("test_start", test_start, ets);
      check("busy", busy, cyc < end_cyc);
      check("all_done", all_done, cyc >= end_cyc);
      if (ets != '0) check("current_test", current_test, cur);
      if (cur >= 0 && lat[cur] != 0 && cyc == launch[cur] + lat[cur]) begin
        test_done[cur] = 1'b1;
        test_pass[cur] = pas[cur];
      end
      if (noise) begin
        for (int j = 0; j < N; j++)
          if (j != cur && $urandom_range(0, 2) == 0) test_done[j] = 1'b1;
        if (cyc < end_cyc && $urandom_range(0, 3) == 0) start = 1'b1;
      end
    end
    test_done = '0;
    check("pass_count", pass_count, np);
    check("fail_count", fail_count, nf);
    check("fail_mask", fail_mask, fm);
    check("timeout_mask", timeout_mask, tm);
    if (last >= 0) check("final_idx", current_test, last);
  endtask

  task automatic set_all(input int l, input logic [N-1:0] p);
    for (int i = 0; i < N; i++) lat[i] = l;
    pas = p;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);
    check("rst_test_start", test_start, 0);
    check("rst_counts", {pass_count, fail_count}, 0);
    check("rst_masks", {fail_mask, timeout_mask}, 0);
    check("rst_idx", current_test, 0);
    rst_n = 1'b1;

    set_all(3, 4'b1111);          run_seq(4'b0000, 1'b0);
    set_all(3, 4'b1011);          run_seq(4'b0000, 1'b0);
    set_all(3, 4'b1111); lat[1] = 0; run_seq(4'b0000, 1'b0);
    set_all(3, 4'b1111); lat[1] = TO; run_seq(4'b0000, 1'b0);
    set_all(3, 4'b1111);          run_seq(4'b1010, 1'b0);
    set_all(3, 4'b1111);          run_seq(4'b1111, 1'b0);
    set_all(3, 4'b1111);          run_seq(4'b0000, 1'b1);

    // Reset mid-WAIT on channel 1, after channel 0 has already passed.
    set_all(3, 4'b1111);
    @(negedge clk);
    start = 1'b1; skip_mask = '0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      test_done = '0;
      if (cyc == 4) begin test_done[0] = 1'b1; test_pass[0] = 1'b1; end
    end
    check("pre_rst_pass", pass_count, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_test_start", test_start, 0);
    check("mid_rst_counts", {pass_count, fail_count}, 0);
    check("mid_rst_masks", {fail_mask, timeout_mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(4'b0000, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, TO);
      pas = N'($urandom);
      run_seq(($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
